fetch_queue: RTL

//   Parametrised IF->ID instruction buffer; next generation of the single-entry IF/ID stage register.

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/sat_counter.sv | 27 ++
 rtl/fetch_queue.sv | 123 ++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants and helpers for the fetch/decode front end
//   NOP_INSTR      : instruction word presented to decode when the queue is empty
//   PC_W_DEF       : default program counter width
//   INSTR_W_DEF    : default instruction word width
//   clog2()        : elaboration-time ceiling log2, used to size pointers
package cpu_pkg;

    localparam int PC_W_DEF    = 32;
    localparam int INSTR_W_DEF = 32;

    localparam logic [INSTR_W_DEF-1:0] NOP_INSTR = 32'h0000_0000;

    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result++;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter for performance statistics
//   clk_i  in  clock
//   rst_i  in  asynchronous active-low reset, clears the count
//   inc_i  in  count this cycle
//   cnt_o  out current count, holds at all-ones instead of wrapping
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - IF->ID instruction buffer with flush and stall/bubble counters
//   clk_i         in  clock
//   rst_i         in  asynchronous active-low reset
//   flush_i       in  discard all entries (taken branch/jump)
//   push_valid_i  in  fetch presents {push_pc_i, push_instr_i}
//   push_ready_o  out queue has a free entry
//   pop_valid_o   out head entry is valid for decode
//   pop_ready_i   in  decode consumes the head
//   pop_pc_o      out head pc, 0 when empty
//   pop_instr_o   out head instruction, NOP when empty
//   count_o       out number of occupied entries, 0..DEPTH
//   stall_cnt_o   out cycles with a valid head that decode did not take
//   bubble_cnt_o  out cycles decode was ready but the queue was empty
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int PC_W    = PC_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int DEPTH   = 4,
    parameter int CNT_W   = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     push_valid_i,
    output logic                     push_ready_o,
    input  logic [PC_W-1:0]          push_pc_i,
    input  logic [INSTR_W-1:0]       push_instr_i,
    output logic                     pop_valid_o,
    input  logic                     pop_ready_i,
    output logic [PC_W-1:0]          pop_pc_o,
    output logic [INSTR_W-1:0]       pop_instr_o,
    output logic [clog2(DEPTH):0]    count_o,
    output logic [CNT_W-1:0]         stall_cnt_o,
    output logic [CNT_W-1:0]         bubble_cnt_o
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CQ_W  = PTR_W + 1;

    logic [PC_W-1:0]    mem_pc    [DEPTH];
    logic [INSTR_W-1:0] mem_instr [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CQ_W-1:0]  count_q;

    logic push_fire;
    logic pop_fire;
    logic stall_inc;
    logic bubble_inc;

    // Ready depends on occupancy only, so fetch never sees a combinational
    // path from decode's stall signal.
    assign push_ready_o = (count_q != CQ_W'(DEPTH));
    assign pop_valid_o  = (count_q != '0);

    // Flush overrides both handshakes; that cycle moves no data and is not
    // attributed to either performance counter.
    always_comb begin
        push_fire  = push_valid_i && push_ready_o && !flush_i;
        pop_fire   = pop_valid_o && pop_ready_i && !flush_i;
        stall_inc  = pop_valid_o && !pop_ready_i && !flush_i;
        bubble_inc = pop_ready_i && !pop_valid_o && !flush_i;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // DEPTH is a power of two, so pointer overflow is the wrap.
            if (push_fire) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_fire) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push_fire, pop_fire})
                2'b10:   count_q <= count_q + CQ_W'(1);
                2'b01:   count_q <= count_q - CQ_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload storage needs no reset: count_q gates every read.
    always_ff @(posedge clk_i) begin
        if (push_fire) begin
            mem_pc[wr_ptr_q]    <= push_pc_i;
            mem_instr[wr_ptr_q] <= push_instr_i;
        end
    end

    // First-word-fall-through head; empty queue shows pc 0 and a NOP.
    assign pop_pc_o    = pop_valid_o ? mem_pc[rd_ptr_q]    : '0;
    assign pop_instr_o = pop_valid_o ? mem_instr[rd_ptr_q] : INSTR_W'(NOP_INSTR);
    assign count_o     = count_q;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (stall_inc),
        .cnt_o (stall_cnt_o)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_bubble_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (bubble_inc),
        .cnt_o (bubble_cnt_o)
    );

endmodule
